// File: rtl/ps_pkg.sv
// Shared constants and state encoding for the power-supply ADC averager.
package ps_pkg;

  localparam int unsigned ADC_W       = 12;
  localparam int unsigned PS_W        = 10;
  localparam int unsigned CH_W        = 5;
  // Right shift that maps a 12-bit sample onto the 10-bit psDig range
  localparam int unsigned SCALE_SHIFT = ADC_W - PS_W;

  typedef enum logic [1:0] {
    IDLE,
    DISC,
    ACCUM
  } state_t;

endpackage

// File: rtl/ps_adc_avg_if.sv
// ADC response stream: one single-cycle valid per sample, tagged with its channel.
interface ps_adc_avg_if;
  import ps_pkg::*;

  logic             valid;
  logic [CH_W-1:0]  channel;
  logic [ADC_W-1:0] data;

  modport master (output valid, channel, data);
  modport slave  (input  valid, channel, data);

endinterface

// File: rtl/ps_avg_scale.sv
// Scales a boxcar sum down to the 10-bit psDig word.
// PS_ADC_ROUND_EN selects round-half-up with saturation instead of truncation.
module ps_avg_scale
  import ps_pkg::*;
#(
  parameter int unsigned LOG2_AVG = 3
) (
  input  logic [ADC_W+LOG2_AVG-1:0] sum,
  output logic [PS_W-1:0]           ps_c
);

  localparam int unsigned SUM_W = ADC_W + LOG2_AVG;
  localparam int unsigned SH    = LOG2_AVG + SCALE_SHIFT;

`ifdef PS_ADC_ROUND_EN
  localparam logic [SUM_W:0] RND = (SUM_W+1)'(1) << (SH - 1);

  logic [SUM_W:0] rounded;
  logic [SUM_W:0] shifted;

  // One extra bit absorbs the rounding carry before the clamp
  always_comb begin
    rounded = {1'b0, sum} + RND;
    shifted = rounded >> SH;
    if (|shifted[SUM_W:PS_W]) ps_c = {PS_W{1'b1}};
    else                      ps_c = shifted[PS_W-1:0];
  end
`else
  always_comb begin
    ps_c = PS_W'(sum >> SH);
  end
`endif

endmodule

// File: rtl/ps_adc_avg.sv
// Channel filter, settling discard and 2^LOG2_AVG boxcar average producing psDig.
// Optional PS_ADC_ROUND_EN (inside ps_avg_scale) rounds instead of truncating.
module ps_adc_avg
  import ps_pkg::*;
#(
  parameter int unsigned CHANNEL  = 1,
  parameter int unsigned LOG2_AVG = 3,
  parameter int unsigned DISCARD  = 2
) (
  input  logic            clk,
  input  logic            i_Rst_L,
  input  logic            enable,
  ps_adc_avg_if.slave     rsp,
  input  logic [PS_W-1:0] lo_thresh,
  input  logic [PS_W-1:0] hi_thresh,
  output logic [PS_W-1:0] psDig,
  output logic            dig_valid,
  output logic            dig_rdy,
  output logic            under,
  output logic            over
);

  localparam int unsigned SUM_W  = ADC_W + LOG2_AVG;
  localparam int unsigned CNT_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned DISC_W = 4;

  localparam logic [CNT_W-1:0]  LAST_SAMP = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [DISC_W-1:0] LAST_DISC = DISC_W'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam state_t            RUN_START = (DISCARD > 0) ? DISC : ACCUM;

  state_t            state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  samp_q, samp_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic              valid_q, valid_d;
  logic              rdy_q, rdy_d;
  logic              under_q, under_d;
  logic              over_q, over_d;

  logic              accept_c;
  logic [SUM_W-1:0]  sum_c;
  logic [PS_W-1:0]   scaled_c;

  assign accept_c = rsp.valid && (rsp.channel == CH_W'(CHANNEL)) && (state_q != IDLE);
  assign sum_c    = acc_q + SUM_W'(rsp.data);

  ps_avg_scale #(.LOG2_AVG(LOG2_AVG)) u_scale (
    .sum  (sum_c),
    .ps_c (scaled_c)
  );

  // Next-state and result logic; enable low overrides everything
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    samp_d  = samp_q;
    disc_d  = disc_q;
    ps_d    = ps_q;
    valid_d = 1'b0;
    rdy_d   = rdy_q;
    under_d = under_q;
    over_d  = over_q;

    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
      samp_d  = '0;
      disc_d  = '0;
      rdy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN_START;
          acc_d   = '0;
          samp_d  = '0;
          disc_d  = '0;
          rdy_d   = 1'b0;
        end
        DISC: begin
          if (accept_c) begin
            disc_d = disc_q + DISC_W'(1);
            if (disc_q == LAST_DISC) state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept_c) begin
            if (samp_q == LAST_SAMP) begin
              ps_d    = scaled_c;
              valid_d = 1'b1;
              rdy_d   = 1'b1;
              under_d = scaled_c < lo_thresh;
              over_d  = scaled_c > hi_thresh;
              acc_d   = '0;
              samp_d  = '0;
            end else begin
              acc_d  = sum_c;
              samp_d = samp_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      acc_q   <= '0;
      samp_q  <= '0;
      disc_q  <= '0;
      ps_q    <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      samp_q  <= samp_d;
      disc_q  <= disc_d;
      ps_q    <= ps_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign psDig     = ps_q;
  assign dig_valid = valid_q;
  assign dig_rdy   = rdy_q;
  assign under     = under_q;
  assign over      = over_q;

endmodule

// File: tb/tb_ps_adc_avg.sv
// Bench for ps_adc_avg: queue-based average model checked every cycle plus literal expectations.
module tb_ps_adc_avg;

  localparam int CHANNEL  = 1;
  localparam int LOG2_AVG = 3;
  localparam int DISCARD  = 2;
  localparam int NAVG     = 1 << LOG2_AVG;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [9:0] lo_thresh;
  logic [9:0] hi_thresh;
  logic [9:0] psDig;
  logic       dig_valid;
  logic       dig_rdy;
  logic       under;
  logic       over;

  ps_adc_avg_if rsp_if ();

  ps_adc_avg #(
    .CHANNEL (CHANNEL),
    .LOG2_AVG(LOG2_AVG),
    .DISCARD (DISCARD)
  ) dut (
    .clk      (clk),
    .i_Rst_L  (rst_n),
    .enable   (enable),
    .rsp      (rsp_if),
    .lo_thresh(lo_thresh),
    .hi_thresh(hi_thresh),
    .psDig    (psDig),
    .dig_valid(dig_valid),
    .dig_rdy  (dig_rdy),
    .under    (under),
    .over     (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic last_pulse;

  // Behavioural model: what the outputs must be after each edge
  int m_ps, m_valid, m_rdy, m_under, m_over;
  bit m_running;
  int m_seen;
  int q[$];

  function automatic int scale(input int s);
    int v;
`ifdef PS_ADC_ROUND_EN
    v = (s + (1 << (LOG2_AVG + 1))) / (1 << (LOG2_AVG + 2));
    if (v > 1023) v = 1023;
`else
    v = s / (1 << (LOG2_AVG + 2));
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    int s;
    m_valid = 0;
    if (!rst_n) begin
      m_ps = 0; m_rdy = 0; m_under = 0; m_over = 0;
      m_running = 0; m_seen = 0; q.delete();
    end else if (!enable) begin
      m_running = 0; m_rdy = 0; q.delete();
    end else if (!m_running) begin
      m_running = 1; m_seen = 0; q.delete();
    end else if (rsp_if.valid && rsp_if.channel == 5'(CHANNEL)) begin
      if (m_seen < DISCARD) m_seen++;
      else begin
        q.push_back(int'(rsp_if.data));
        if (q.size() == NAVG) begin
          s = 0;
          foreach (q[i]) s += q[i];
          m_ps    = scale(s);
          m_valid = 1;
          m_rdy   = 1;
          m_under = (m_ps < int'(lo_thresh)) ? 1 : 0;
          m_over  = (m_ps > int'(hi_thresh)) ? 1 : 0;
          q.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int c, input int d);
    @(negedge clk);
    rsp_if.valid   = 1'b1;
    rsp_if.channel = 5'(c);
    rsp_if.data    = 12'(d);
    @(posedge clk);
    #1 last_pulse = dig_valid;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rsp_if.valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_enable(input logic v);
    @(negedge clk);
    rsp_if.valid = 1'b0;
    enable       = v;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    rsp_if.valid = 1'b0; rsp_if.channel = '0; rsp_if.data = '0;
    lo_thresh = 10'd0; hi_thresh = 10'd1023;
    last_pulse = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_psDig", 32'(psDig), 0);
    check("reset_valid", 32'(dig_valid), 0);
    check("reset_rdy", 32'(dig_rdy), 0);
    check("reset_under", 32'(under), 0);
    check("reset_over", 32'(over), 0);

    fork
      forever begin
        @(posedge clk);
        #1;
        check("cyc_psDig", 32'(psDig), 32'(m_ps));
        check("cyc_valid", 32'(dig_valid), 32'(m_valid));
        check("cyc_rdy", 32'(dig_rdy), 32'(m_rdy));
        check("cyc_under", 32'(under), 32'(m_under));
        check("cyc_over", 32'(over), 32'(m_over));
      end
    join_none

    @(negedge clk) rst_n = 1'b1;

    // Discard two full-scale samples, then average mid-scale
    set_enable(1'b1);
    send(CHANNEL, 12'hFFF); send(CHANNEL, 12'hFFF);
    for (int i = 0; i < 8; i++) begin
      send(CHANNEL, 12'h800);
      if (i == 6) check("t1_no_early_pulse", 32'(last_pulse), 0);
    end
    check("t1_pulse", 32'(last_pulse), 1);
    idle(2);
    check("t1_psDig", 32'(psDig), 512);
    check("t1_rdy", 32'(dig_rdy), 1);
    check("t1_pulse_single", 32'(dig_valid), 0);

    // Full scale: truncation and rounding both land on 1023
    for (int i = 0; i < 8; i++) send(CHANNEL, 12'hFFF);
    idle(1);
    check("t2_psDig", 32'(psDig), 1023);

    // Sum 124: truncates to 3, rounds to 4
    for (int i = 0; i < 4; i++) send(CHANNEL, 12'h00F);
    for (int i = 0; i < 4; i++) send(CHANNEL, 12'h010);
    idle(1);
`ifdef PS_ADC_ROUND_EN
    check("t3_psDig", 32'(psDig), 4);
`else
    check("t3_psDig", 32'(psDig), 3);
`endif

    // Channel 0 traffic interleaved must be ignored
    for (int i = 0; i < 8; i++) begin
      send(0, 12'h000);
      send(CHANNEL, 12'h800);
      if (i == 6) check("t4_no_early_pulse", 32'(last_pulse), 0);
    end
    check("t4_pulse", 32'(last_pulse), 1);
    idle(1);
    check("t4_psDig", 32'(psDig), 512);

    // Partial sum abandoned by enable drop
    for (int i = 0; i < 5; i++) send(CHANNEL, 12'h400);
    set_enable(1'b0);
    idle(2);
    check("t5_rdy_cleared", 32'(dig_rdy), 0);
    check("t5_psDig_held", 32'(psDig), 512);
    lo_thresh = 10'd300; hi_thresh = 10'd400;
    set_enable(1'b1);
    for (int i = 0; i < 9; i++) send(CHANNEL, 12'h400);
    check("t5_rdy_before", 32'(dig_rdy), 0);
    check("t5_no_pulse", 32'(last_pulse), 0);
    send(CHANNEL, 12'h400);
    check("t5_pulse", 32'(last_pulse), 1);
    idle(1);
    check("t5_psDig", 32'(psDig), 256);
    check("t5_under", 32'(under), 1);
    check("t5_over", 32'(over), 0);
    check("t5_rdy", 32'(dig_rdy), 1);

    // Above window
    for (int i = 0; i < 8; i++) send(CHANNEL, 12'h800);
    idle(1);
    check("t6_psDig", 32'(psDig), 512);
    check("t6_under", 32'(under), 0);
    check("t6_over", 32'(over), 1);

    // Reset in the middle of an average
    for (int i = 0; i < 3; i++) send(CHANNEL, 12'h800);
    @(negedge clk);
    rsp_if.valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_psDig", 32'(psDig), 0);
    check("rst_valid", 32'(dig_valid), 0);
    check("rst_rdy", 32'(dig_rdy), 0);
    check("rst_under", 32'(under), 0);
    check("rst_over", 32'(over), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps_adc_avg.md
Name: ps_adc_avg

Overview:
Conditions raw power-supply sense samples from the on-chip ADC response stream into the 10-bit psDig word consumed by the pot-control stage.
- Filters samples by channel.
- Discards settling samples after enable.
- Boxcar-averages 2^LOG2_AVG samples and scales 12-bit to 10-bit.
- Flags out-of-window results and raises a sticky ready once the first valid average exists.

Parameters:
CHANNEL, 1, ADC channel number accepted; other channels are ignored
LOG2_AVG, 3, log2 of samples per average (legal range 0..6)
DISCARD, 2, samples dropped after each enable rising edge (legal range 0..15)

Ports:
clk  in  1  system clock
i_Rst_L  in  1  synchronous active-low reset
enable  in  1  level; high = run, low = idle/hold
rsp_valid  in  1  ADC response valid, single-cycle per sample
rsp_channel  in  5  ADC response channel
rsp_data  in  12  ADC response sample, unsigned
lo_thresh  in  10  window low limit, unsigned
hi_thresh  in  10  window high limit, unsigned
psDig  out  10  averaged, scaled result
dig_valid  out  1  one-cycle pulse when psDig updates
dig_rdy  out  1  sticky: at least one average completed since enable rose
under  out  1  registered psDig < lo_thresh
over  out  1  registered psDig > hi_thresh

Behaviour:
- Reset (i_Rst_L low at a clk edge): next state is IDLE. psDig=0, dig_valid=0, dig_rdy=0, under=0, over=0, accumulator=0, counters=0. Reset mid-average abandons the partial sum.
- A sample is accepted only when rsp_valid=1, rsp_channel==CHANNEL and the state is DISC or ACCUM. All other responses are ignored.
- IDLE:
  - enable=1 -> DISC if DISCARD>0, else ACCUM. Discard counter and sample counter clear.
  - psDig, under and over hold their values. dig_rdy=0.
- DISC:
  - Each accepted sample increments the discard counter.
  - On the DISCARD-th accepted sample -> ACCUM.
- ACCUM:
  - Accumulator width is 12+LOG2_AVG bits; it adds each accepted sample.
  - On the 2^LOG2_AVG-th accepted sample, the registered result is computed from sum = acc + current sample, and psDig = sum >> (LOG2_AVG+2), truncated.
  - That same edge: dig_valid=1 for exactly one cycle, dig_rdy=1, and under/over are computed from the new psDig vs. thresholds.
  - The accumulator and counter reload to 0 on that edge. The next accepted sample starts a new average, so back-to-back samples lose nothing.
  - Latency: one clk from the final sample's valid cycle to the psDig/dig_valid update.
- enable=0 in any state -> IDLE on the next edge.
  - A partial sum is discarded and dig_rdy clears.
  - dig_valid never asserts in the cycle of the enable=0 transition, even if a final sample arrives simultaneously.
- Threshold inputs are sampled only at the update edge; lo_thresh>hi_thresh may assert both flags, with no special handling.
- LOG2_AVG=0: every accepted sample produces an update (psDig = sample>>2).

Optional Feature:
PS_ADC_ROUND_EN
- Defined: psDig = (sum + 2^(LOG2_AVG+1)) >> (LOG2_AVG+2), saturated to 1023.
- Undefined: truncation as above, with no rounding adder.

Decomposition:
- Shared package ps_pkg holds:
  - ADC_W=12 and PS_W=10 constants.
  - The state enum: IDLE, DISC, ACCUM.
  - A helper constant for the scale shift.
- One sub-module, ps_avg_scale: combinational shift/round/saturate from sum to 10 bits. It holds the PS_ADC_ROUND_EN logic, so the FSM stays macro-free.

Test Plan:
- Defaults, enable=1, 2 discard samples of 0xFFF, then 8 samples of 0x800 on ch1 -> one dig_valid pulse 1 clk after the 8th; psDig=512, dig_rdy=1.
- 8 samples of 0xFFF -> psDig=1023 both with and without PS_ADC_ROUND_EN; with rounding, the saturation path is exercised (sum 32760+16 -> 1024 clamps to 1023).
- 4 samples of 0x00F plus 4 of 0x010 (sum 124) -> psDig=3 without PS_ADC_ROUND_EN, 4 with it.
- Interleave ch0 samples of 0x000 with the ch1 stream of 0x800 -> ch0 ignored; psDig=512; the update occurs only after 8 ch1 samples.
- Deassert enable after 5 samples, re-enable, feed 2+8 samples of 0x400 -> no pulse from the partial sum; dig_rdy low until the new result; psDig=256.
- lo_thresh=300, hi_thresh=400 with results 256 then 512 -> under=1/over=0, then under=0/over=1. i_Rst_L low mid-average -> all outputs 0 on the next edge.
